// File: rtl/debug_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_feeder_pkg: shared state encodings and constants for the VGA debug feeder
// Rev 1.0
// ---------------------------------------------------------------------------
package debug_feeder_pkg;

    typedef enum logic [0:0] {
        CAP_RUN  = 1'b0,
        CAP_HOLD = 1'b1
    } cap_state_e;

    typedef enum logic [1:0] {
        M_WAIT = 2'd0,
        M_REQ  = 2'd1,
        M_PUB  = 2'd2
    } scan_state_e;

    localparam logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF;
    localparam int          DBG_ADDR_W     = 7;
    localparam int          DBG_REGION_BIT = 6;

    // Upper half of the display address space has no backing snapshot entry.
    function automatic logic dbg_addr_unmapped(input logic [DBG_ADDR_W-1:0] addr);
        return addr[DBG_REGION_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_snap_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debug_snap_ram: ENTRIES x 32 read-first memory, one write port, registered read
// Rev 1.0
// ---------------------------------------------------------------------------
module debug_snap_ram #(
    parameter int ENTRIES = 64,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          rzero_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [ENTRIES];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the array gives old data on a same-index write.
    always_ff @(posedge clk) begin
        if (rst || rzero_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_debug_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_debug_feeder: datapath snapshot capture and ROM/RAM scan for the VGA debug display
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_debug_feeder
    import debug_feeder_pkg::*;
#(
    parameter int          SNAP_ENTRIES = 64,
    parameter int          SCAN_WORDS   = 128,
    parameter int          SCAN_DIV     = 16,
    parameter int          ACK_TIMEOUT  = 15,
    parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        step,
    output logic [5:0]  dbg_sel,
    input  logic [31:0] dbg_val,
    input  logic [6:0]  Debug_addr,
    output logic [31:0] Debug_data,
    input  logic        ram_sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MEM_Addr,
    output logic [31:0] MEM_Data,
    output logic        cap_busy
);

    localparam int SNAP_W = $clog2(SNAP_ENTRIES);
    localparam int SCAN_W = $clog2(SCAN_WORDS);
    localparam int DIV_W  = $clog2(SCAN_DIV + 1);
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

    // ---------------- capture sweep ----------------
    cap_state_e        cap_state_q, cap_state_d;
    logic [SNAP_W-1:0] cap_idx_q, cap_idx_d;
    logic              cap_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state_q <= CAP_RUN;
            cap_idx_q   <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    // Outputs are masked while reset is held so the display never sees a stale sweep.
    always_comb begin
        cap_state_d = cap_state_q;
        cap_idx_d   = cap_idx_q;
        cap_we      = 1'b0;
        dbg_sel     = '0;
        cap_busy    = 1'b0;
        case (cap_state_q)
            CAP_RUN: begin
                cap_we    = !rst;
                cap_busy  = !rst;
                dbg_sel   = rst ? '0 : cap_idx_q;
                cap_idx_d = cap_idx_q + 1'b1;
                if (cap_idx_q == SNAP_W'(SNAP_ENTRIES - 1)) begin
                    cap_idx_d = '0;
                    if (freeze) begin
                        cap_state_d = CAP_HOLD;
                    end
                end
            end
            CAP_HOLD: begin
                if (step || !freeze) begin
                    cap_state_d = CAP_RUN;
                end
            end
            default: cap_state_d = CAP_RUN;
        endcase
    end

    debug_snap_ram #(
        .ENTRIES (SNAP_ENTRIES),
        .AW      (SNAP_W)
    ) u_snap (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cap_we),
        .waddr_i (cap_idx_q),
        .wdata_i (dbg_val),
        .raddr_i (Debug_addr[SNAP_W-1:0]),
        .rzero_i (dbg_addr_unmapped(Debug_addr)),
        .rdata_o (Debug_data)
    );

    // ---------------- memory scan ----------------
    scan_state_e       scan_state_q, scan_state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SCAN_W-1:0] scan_idx_q, scan_idx_d;
    logic              sel_q, sel_d;
    logic              abort_q, abort_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       pub_addr_q, pub_addr_d;
    logic [31:0]       pub_data_q, pub_data_d;
    logic              sel_changed;
    logic [31:0]       scan_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_state_q <= M_WAIT;
            div_q        <= '0;
            tmo_q        <= '0;
            scan_idx_q   <= '0;
            sel_q        <= ram_sel;
            abort_q      <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            rdata_q      <= '0;
            pub_addr_q   <= '0;
            pub_data_q   <= '0;
        end else begin
            scan_state_q <= scan_state_d;
            div_q        <= div_d;
            tmo_q        <= tmo_d;
            scan_idx_q   <= scan_idx_d;
            sel_q        <= sel_d;
            abort_q      <= abort_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            pub_addr_q   <= pub_addr_d;
            pub_data_q   <= pub_data_d;
        end
    end

    assign sel_changed = (ram_sel != sel_q);
    assign scan_base   = sel_q ? RAM_BASE : ROM_BASE;

    always_comb begin
        scan_state_d = scan_state_q;
        div_d        = div_q;
        tmo_d        = tmo_q;
        scan_idx_d   = scan_idx_q;
        sel_d        = sel_q;
        abort_d      = abort_q;
        req_d        = req_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        pub_addr_d   = pub_addr_q;
        pub_data_d   = pub_data_q;
        case (scan_state_q)
            M_WAIT: begin
                if (sel_changed) begin
                    sel_d      = ram_sel;
                    scan_idx_d = '0;
                    div_d      = '0;
                end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d        = '0;
                    tmo_d        = '0;
                    abort_d      = 1'b0;
                    req_d        = 1'b1;
                    addr_d       = scan_base + {{(32-SCAN_W-2){1'b0}}, scan_idx_q, 2'b00};
                    scan_state_d = M_REQ;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            M_REQ: begin
                // A source switch lets the bus transaction complete but drops its result.
                abort_d = abort_q | sel_changed;
                tmo_d   = tmo_q + 1'b1;
                if (mem_ack || (tmo_q == TMO_W'(ACK_TIMEOUT - 1))) begin
                    req_d   = 1'b0;
                    rdata_d = mem_ack ? mem_rdata : TIMEOUT_DATA;
                    if (abort_q || sel_changed) begin
                        sel_d        = ram_sel;
                        scan_idx_d   = '0;
                        div_d        = '0;
                        scan_state_d = M_WAIT;
                    end else begin
                        scan_state_d = M_PUB;
                    end
                end
            end
            M_PUB: begin
                pub_addr_d   = addr_q;
                pub_data_d   = rdata_q;
                scan_idx_d   = (scan_idx_q == SCAN_W'(SCAN_WORDS - 1)) ? '0 : scan_idx_q + 1'b1;
                div_d        = '0;
                scan_state_d = M_WAIT;
            end
            default: scan_state_d = M_WAIT;
        endcase
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign mem_sel  = sel_q;
    assign MEM_Addr = pub_addr_q;
    assign MEM_Data = pub_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_debug_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_debug_feeder: randomized bench with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_debug_feeder;

    localparam int          SCAN_DIV    = 4;
    localparam int          ACK_TIMEOUT = 15;
    localparam int          SCAN_WORDS  = 128;
    localparam logic [31:0] ROM_B       = 32'h0000_0000;
    localparam logic [31:0] RAM_B       = 32'h0004_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        step = 1'b0;
    logic [5:0]  dbg_sel;
    logic [31:0] dbg_val;
    logic [6:0]  Debug_addr = 7'd0;
    logic [31:0] Debug_data;
    logic        ram_sel = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_sel;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_Data;
    logic        cap_busy;
    logic [31:0] dbg_base = 32'hA000_0000;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dbg_val = dbg_base + {26'd0, dbg_sel};

    vga_debug_feeder #(
        .SNAP_ENTRIES (64),
        .SCAN_WORDS   (SCAN_WORDS),
        .SCAN_DIV     (SCAN_DIV),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .ROM_BASE     (ROM_B),
        .RAM_BASE     (RAM_B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .step       (step),
        .dbg_sel    (dbg_sel),
        .dbg_val    (dbg_val),
        .Debug_addr (Debug_addr),
        .Debug_data (Debug_data),
        .ram_sel    (ram_sel),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_sel    (mem_sel),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .MEM_Addr   (MEM_Addr),
        .MEM_Data   (MEM_Data),
        .cap_busy   (cap_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit          started   = 1'b0;
    bit          after_rst = 1'b0;
    bit          noack_mode = 1'b0;
    logic [31:0] snap_m [64];
    bit          snap_v [64];
    bit          cap_run_m = 1'b1;
    int          pos_m = 0;
    logic [31:0] rd_exp = 32'd0;
    bit          rd_known = 1'b0;

    bit          sel_m = 1'b0;
    int          idx_m = 0;
    logic [31:0] exp_maddr = 32'd0, exp_mdata = 32'd0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'd0, pend_data = 32'd0;
    bit          prev_req = 1'b0;
    int          req_len = 0, gap_cnt = 0, wait_cnt = 0, tr_delay = 0;
    bit          gap_ok = 1'b0, last_pub = 1'b0, tr_abort = 1'b0, tr_lastsel = 1'b0;
    logic [31:0] tr_addr = 32'd0;

    function automatic int pick_delay(input bit no_ack);
        int r;
        r = $urandom_range(0, 19);
        if (no_ack)  return 40;
        if (r < 12)  return r % 4;
        if (r < 14)  return 2;
        if (r == 14) return ACK_TIMEOUT - 2;
        if (r == 15) return ACK_TIMEOUT - 1;
        if (r == 16) return ACK_TIMEOUT;
        return 30;
    endfunction

    // Checks outputs of the current cycle, then advances the model by the
    // inputs the DUT will sample at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("cap_busy", 32'(cap_busy), 32'(cap_run_m && !rst));
                check("dbg_sel", 32'(dbg_sel), (cap_run_m && !rst) ? 32'(pos_m) : 32'd0);
                if (rd_known) check("Debug_data", Debug_data, rd_exp);
                if (pend) begin
                    exp_maddr = pend_addr;
                    exp_mdata = pend_data;
                    pend = 1'b0;
                end
                check("MEM_Addr", MEM_Addr, exp_maddr);
                check("MEM_Data", MEM_Data, exp_mdata);
                if (after_rst) begin
                    check("rst_mem_req", 32'(mem_req), 32'd0);
                    check("rst_mem_addr", mem_addr, 32'd0);
                    after_rst = 1'b0;
                end
            end
            if (rst) begin
                started   = 1'b1;
                after_rst = 1'b1;
                cap_run_m = 1'b1;
                pos_m     = 0;
                rd_exp    = 32'd0;
                rd_known  = 1'b1;
                sel_m     = ram_sel;
                idx_m     = 0;
                exp_maddr = 32'd0;
                exp_mdata = 32'd0;
                pend      = 1'b0;
                prev_req  = 1'b0;
                gap_ok    = 1'b0;
                gap_cnt   = 0;
            end else begin
                rd_exp   = Debug_addr[6] ? 32'd0 : snap_m[Debug_addr[5:0]];
                rd_known = Debug_addr[6] || snap_v[Debug_addr[5:0]];
                if (cap_run_m) begin
                    snap_m[pos_m] = dbg_base + 32'(pos_m);
                    snap_v[pos_m] = 1'b1;
                    if (pos_m == 63) begin
                        pos_m = 0;
                        cap_run_m = !freeze;
                    end else begin
                        pos_m++;
                    end
                end else if (step || !freeze) begin
                    cap_run_m = 1'b1;
                end

                if (mem_req && !prev_req) begin
                    tr_addr = (sel_m ? RAM_B : ROM_B) + 32'(idx_m * 4);
                    check("req_addr", mem_addr, tr_addr);
                    check("req_sel", 32'(mem_sel), 32'(sel_m));
                    if (gap_ok) check("req_gap", 32'(gap_cnt), last_pub ? 32'(SCAN_DIV + 1) : 32'(SCAN_DIV));
                    req_len  = 0;
                    tr_abort = 1'b0;
                    tr_delay = pick_delay(noack_mode);
                    wait_cnt = 0;
                end
                if (mem_req) begin
                    req_len++;
                    if (ram_sel != sel_m) tr_abort = 1'b1;
                    tr_lastsel = ram_sel;
                end else begin
                    if (prev_req) begin
                        check("req_len", 32'(req_len),
                              (tr_delay < ACK_TIMEOUT) ? 32'(tr_delay + 1) : 32'(ACK_TIMEOUT));
                        if (tr_abort) begin
                            sel_m    = tr_lastsel;
                            idx_m    = 0;
                            last_pub = 1'b0;
                        end else begin
                            pend      = 1'b1;
                            pend_addr = tr_addr;
                            pend_data = (tr_delay < ACK_TIMEOUT) ? (tr_addr ^ 32'h5555_5555) : 32'hFFFF_FFFF;
                            idx_m     = (idx_m + 1) % SCAN_WORDS;
                            last_pub  = 1'b1;
                        end
                        gap_cnt = 0;
                        gap_ok  = 1'b1;
                    end
                    gap_cnt++;
                    if (ram_sel != sel_m) begin
                        sel_m  = ram_sel;
                        idx_m  = 0;
                        gap_ok = 1'b0;
                    end
                    if (gap_cnt > 40) begin
                        check("req_stall", 32'(gap_cnt), 32'(SCAN_DIV + 1));
                        gap_cnt = 0;
                        gap_ok  = 1'b0;
                    end
                end
                prev_req = mem_req;
            end

            // Memory responder: ack after tr_delay request cycles, stray acks otherwise.
            if (mem_req && !rst) begin
                if (wait_cnt == tr_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 32'h5555_5555;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                wait_cnt++;
            end else begin
                mem_ack   = ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- stimulus ----------------
    int sel_gap = 0;

    task automatic run(input int n, input int step_pct, input bit sel_toggle);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            Debug_addr = 7'($urandom);
            if ($urandom_range(0, 3) == 0) dbg_base = $urandom;
            step = ($urandom_range(0, 99) < step_pct);
            if (sel_toggle && sel_gap == 0 && $urandom_range(0, 99) == 0) begin
                ram_sel = !ram_sel;
                sel_gap = 6;
            end
            if (sel_gap > 0) sel_gap--;
        end
        step = 1'b0;
    endtask

    task automatic wait_for_req(input bit need_busy);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (mem_req && (!need_busy || (cap_busy && dbg_sel != 6'd0))) break;
        end
        check("wait_req", 32'(mem_req), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run(200, 0, 1'b0);

        @(posedge clk); #1 Debug_addr = 7'h05;
        @(posedge clk); #1 Debug_addr = 7'h45;
        @(posedge clk); #1 Debug_addr = 7'h3F;

        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (dbg_sel == 6'd20) break;
        end
        check("freeze_at_20", 32'(dbg_sel), 32'd20);
        freeze = 1'b1;
        run(150, 0, 1'b0);
        run(300, 2, 1'b0);
        freeze = 1'b0;
        run(2000, 1, 1'b0);
        run(800, 1, 1'b1);

        noack_mode = 1'b1;
        run(100, 0, 1'b0);
        noack_mode = 1'b0;
        run(20, 0, 1'b0);

        wait_for_req(1'b0);
        ram_sel = !ram_sel;
        run(60, 0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            wait_for_req(1'b1);
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            run(100, 0, 1'b0);
        end

        run(20, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_debug_feeder.md
Name: vga_debug_feeder

Overview:
Source side of the VGA debug display interface.
- Responds to the display's 7-bit Debug_addr with a registered 32-bit Debug_data word, read from a 64-entry snapshot buffer.
- The snapshot buffer is filled by a capture sweep over the datapath debug mux (regs x0–x31, pipeline signals 32–63).
- A memory scan engine walks ROM or RAM one word at a time over a req/ack port. It publishes each word as a stable MEM_Addr/MEM_Data pair for the display's memory cache.
- Sits between the CPU datapath/memory and the VGA debug display.

Parameters:
SNAP_ENTRIES, 64, snapshot depth; index width 6.
SCAN_WORDS, 128, words per scan pass; address offset width 7.
SCAN_DIV, 16, idle cycles between scan transactions (>=1).
ACK_TIMEOUT, 15, cycles in M_REQ before the transaction is abandoned.
ROM_BASE, 32'h0000_0000, byte base address of the ROM scan.
RAM_BASE, 32'h0000_0000, byte base address of the RAM scan.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
freeze  in  1  1 = stop live capture after the current sweep.
step  in  1  one-cycle pulse; starts one full sweep while frozen.
dbg_sel  out  6  index presented to the datapath debug mux.
dbg_val  in  32  combinational datapath value for dbg_sel.
Debug_addr  in  7  display read address.
Debug_data  out  32  registered read data.
ram_sel  in  1  0 = scan ROM, 1 = scan RAM.
mem_req  out  1  scan read request.
mem_addr  out  32  scan read byte address.
mem_sel  out  1  memory select for the request (copy of the latched ram_sel).
mem_ack  in  1  read data valid.
mem_rdata  in  32  read data.
MEM_Addr  out  32  published word address.
MEM_Data  out  32  published word data.
cap_busy  out  1  capture sweep in progress.

Behaviour:
Reset values:
- Debug_data, MEM_Addr, MEM_Data, mem_addr = 0.
- mem_req, cap_busy = 0.
- dbg_sel = 0.
- Capture FSM enters CAP_RUN.
- Scan FSM enters M_WAIT with the divider counter cleared.
- Scan index = 0; latched select = ram_sel.
- Snapshot contents are not reset.

Read port:
- Debug_data <= Debug_addr[6] ? 0 : buf[Debug_addr[5:0]].
- Latency exactly 1 clk.
- A read and a write to the same index in the same cycle return the old value (read-first).

Capture FSM:
- CAP_RUN: each cycle writes buf[idx] <= dbg_val, with dbg_sel = idx, then idx++. cap_busy = 1.
- At idx = 63 the write completes. Then: freeze = 0 → idx wraps to 0 and the FSM stays in CAP_RUN; freeze = 1 → go to CAP_HOLD with idx = 0.
- Asserting freeze mid-sweep does not abort; the sweep finishes through 63.
- CAP_HOLD: cap_busy = 0, no writes, dbg_sel = 0.
  - step = 1 → CAP_RUN for one sweep, then back to CAP_HOLD if freeze is still 1.
  - freeze = 0 → CAP_RUN.
- step is ignored in CAP_RUN.

Scan FSM:
- M_WAIT: counts SCAN_DIV cycles. At terminal count: mem_addr <= base + {idx, 2'b00}, where base comes from the latched select. Assert mem_req, go to M_REQ.
- M_REQ: mem_req held until mem_ack.
  - On ack: capture mem_rdata, go to M_PUB.
  - If ACK_TIMEOUT cycles pass without ack: capture 32'hFFFF_FFFF, go to M_PUB.
  - mem_req falls in the cycle after ack/timeout.
- M_PUB (1 cycle): MEM_Addr and MEM_Data update in the same cycle. idx = (idx + 1) mod SCAN_WORDS. Go to M_WAIT.
- MEM_Addr/MEM_Data change only in M_PUB; they are otherwise held stable.
- ram_sel change, detected against the latched value:
  - in M_WAIT: re-latch, idx = 0, restart the divider count;
  - in M_REQ: finish the transaction, skip publishing, then re-latch, idx = 0, go to M_WAIT.
- An ack arriving in the same cycle as the timeout terminal count counts as an ack.
- mem_ack outside M_REQ is ignored.
- Reset mid-transaction drops mem_req in the next cycle; any pending data is discarded.

Decomposition:
- Shared package debug_feeder_pkg: capture/scan state encodings, TIMEOUT_DATA = 32'hFFFF_FFFF, the Debug_addr bit-6 region split.
- One sub-module: debug_snap_ram, a SNAP_ENTRIES x 32 read-first memory with one write port and one registered read port.

Test Plan:
- Capture and readback: freeze = 0, dbg_val = 32'hA000_0000 + dbg_sel; after 64 cycles, Debug_addr = 7'h05 → Debug_data = 32'hA000_0005 one clk later; Debug_addr = 7'h45 → 0.
- Freeze mid-sweep: freeze = 1 at idx 20 → writes continue through idx 63, then cap_busy = 0. Change dbg_val → buffer unchanged. step pulse → one sweep of 64 writes, then hold.
- Scan with ack: SCAN_DIV = 4, ram_sel = 0, mem_ack 2 cycles after each req, mem_rdata = addr ^ 32'h5555_5555 → MEM_Addr = 0, 4, 8…, with matching MEM_Data. After 128 words MEM_Addr wraps from 0x1FC to 0.
- Timeout: mem_ack never asserted → mem_req high for 15 cycles, then MEM_Data = 32'hFFFF_FFFF published with the correct MEM_Addr; idx advances.
- Source switch mid-request: toggle ram_sel while in M_REQ → no publish for that transaction; next request goes to RAM_BASE + 0 with mem_sel = 1.
- Reset mid-operation: assert rst while in M_REQ and mid-sweep → next cycle mem_req = 0, MEM_Addr = MEM_Data = Debug_data = 0, capture restarts at idx 0.
